// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus iterative multiply/divide unit.
// One request in flight; result held until out_ready.
module alu_mdu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SRA    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SLL    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_EQ     = 5'd9;
  localparam logic [4:0] OP_SLTU   = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd11;
  localparam logic [4:0] OP_MULH   = 5'd12;
  localparam logic [4:0] OP_MULHSU = 5'd13;
  localparam logic [4:0] OP_MULHU  = 5'd14;
  localparam logic [4:0] OP_DIV    = 5'd15;
  localparam logic [4:0] OP_DIVU   = 5'd16;
  localparam logic [4:0] OP_REM    = 5'd17;
  localparam logic [4:0] OP_REMU   = 5'd18;

  localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

  state_t            state, state_nxt;
  logic [4:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q, m_q, out_q;
  logic [2*XLEN-1:0] p_q, p_nxt, prod;
  logic              neg_q, aneg_q;
  logic [SHW-1:0]    cnt;

  logic            is_mdu, is_div, is_div_q, last;
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, alu_res, mdu_res;
  logic [XLEN-1:0] quo, rem;
  logic [XLEN:0]   sum, sh, diff;
  logic [SHW-1:0]  shamt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out       = out_q;

  assign is_mdu   = (op >= OP_MUL) && (op <= OP_REMU);
  assign is_div   = (op >= OP_DIV);
  assign is_div_q = (op_q >= OP_DIV);
  assign last     = (cnt == LAST);
  assign shamt    = operand_b[SHW-1:0];

  assign a_sgn = (op == OP_MULH) || (op == OP_MULHSU) ||
                 (op == OP_DIV) || (op == OP_REM);
  assign b_sgn = (op == OP_MULH) || (op == OP_DIV) ||
                 (op == OP_REM);
  assign a_neg = a_sgn & operand_a[XLEN-1];
  assign b_neg = b_sgn & operand_b[XLEN-1];
  assign a_mag = a_neg ? -operand_a : operand_a;
  assign b_mag = b_neg ? -operand_b : operand_b;

  // single-cycle ALU result, evaluated on the accepted inputs
  always_comb begin
    alu_res = operand_a + operand_b;
    unique case (op)
      OP_SUB:  alu_res = operand_a - operand_b;
      OP_AND:  alu_res = operand_a & operand_b;
      OP_OR:   alu_res = operand_a | operand_b;
      OP_XOR:  alu_res = operand_a ^ operand_b;
      OP_SRA:  alu_res = $signed(operand_a) >>> shamt;
      OP_SRL:  alu_res = operand_a >> shamt;
      OP_SLL:  alu_res = operand_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}},
                          $signed(operand_a) < $signed(operand_b)};
      OP_EQ:   alu_res = {{(XLEN-1){1'b0}}, operand_a == operand_b};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
      default: alu_res = operand_a + operand_b;
    endcase
  end

  // one shift-add or restoring-divide step on magnitudes
  always_comb begin
    sum  = {1'b0, p_q[2*XLEN-1:XLEN]} +
           ({1'b0, m_q} & {(XLEN+1){p_q[0]}});
    sh   = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    diff = sh - {1'b0, m_q};
    if (is_div_q) begin
      if (diff[XLEN])
        p_nxt = {sh[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
      else
        p_nxt = {diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
    end else begin
      p_nxt = {sum, p_q[XLEN-1:1]};
    end
  end

  // sign fix-up and divide-by-zero handling of the final step
  always_comb begin
    prod    = neg_q ? -p_nxt : p_nxt;
    quo     = p_nxt[XLEN-1:0];
    rem     = p_nxt[2*XLEN-1:XLEN];
    mdu_res = prod[XLEN-1:0];
    unique case (op_q)
      OP_MULH, OP_MULHSU, OP_MULHU:
        mdu_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:
        mdu_res = (b_q == '0) ? '1 : (neg_q ? -quo : quo);
      OP_REM, OP_REMU:
        mdu_res = (b_q == '0) ? a_q : (aneg_q ? -rem : rem);
      default:
        mdu_res = prod[XLEN-1:0];
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = is_mdu ? BUSY : DONE;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture, engine iteration and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      p_q    <= '0;
      neg_q  <= 1'b0;
      aneg_q <= 1'b0;
      cnt    <= '0;
      out_q  <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          op_q   <= op;
          a_q    <= operand_a;
          b_q    <= operand_b;
          neg_q  <= a_neg ^ b_neg;
          aneg_q <= a_neg;
          cnt    <= '0;
          if (is_mdu) begin
            p_q <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
            m_q <= is_div ? b_mag : a_mag;
          end else begin
            out_q <= alu_res;
          end
        end
        BUSY: begin
          p_q <= p_nxt;
          cnt <= cnt + 1'b1;
          if (last) out_q <= mdu_res;
        end
        default: ;
      endcase
    end
  end

endmodule
